match_sequencer: RTL

- Sequences a Pong match around the existing game datapath: attract/idle, serve countdown, live play, point pause, game over.
- Consumes goal events from game logic and the per-frame tick from the display.
- Gates ball/paddle motion via run_o, requests ball re-centre via serve_o, and keeps both scores.
- Sits in game_top between the keys, game logic and display.

---
 rtl/match_sequencer_pkg.sv | 33 +++
 rtl/match_sequencer_if.sv | 35 +++
 rtl/match_sequencer_frame_timer.sv | 31 +++
 rtl/match_sequencer.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/match_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : match_sequencer_pkg
// Brief    : Shared match states, default game constants and the counter-width helper.
// Revision : 1.0
// ============================================================================
package match_sequencer_pkg;

    localparam int KEYS_W       = 4;
    localparam int SCORE_W      = 4;
    localparam int WIN_SCORE    = 7;
    localparam int SERVE_FRAMES = 60;
    localparam int POINT_FRAMES = 90;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_POINT      = 3'd3,
        ST_GAME_OVER  = 3'd4
    } match_state_t;

    // The timer holds at most (frames - 1), so clog2 of the larger delay is enough.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/match_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : match_sequencer_if
// Brief    : Key, frame and goal inputs plus run/serve/score outputs of the sequencer.
// Revision : 1.0
// ============================================================================
interface match_sequencer_if #(
    parameter int KEYS_W  = match_sequencer_pkg::KEYS_W,
    parameter int SCORE_W = match_sequencer_pkg::SCORE_W
) ();
    logic [KEYS_W-1:0]  keys_i;
    logic               new_frame_i;
    logic               player_goal_i;
    logic               enemy_goal_i;
    logic               run_o;
    logic               serve_o;
    logic               serve_dir_o;
    logic [SCORE_W-1:0] player_score_o;
    logic [SCORE_W-1:0] enemy_score_o;
    logic               winner_o;
    logic [2:0]         state_o;

    modport master (
        output keys_i, new_frame_i, player_goal_i, enemy_goal_i,
        input  run_o, serve_o, serve_dir_o, player_score_o, enemy_score_o,
               winner_o, state_o
    );

    modport slave (
        input  keys_i, new_frame_i, player_goal_i, enemy_goal_i,
        output run_o, serve_o, serve_dir_o, player_score_o, enemy_score_o,
               winner_o, state_o
    );
endinterface
`default_nettype wire

// File: rtl/match_sequencer_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : match_sequencer_frame_timer
// Brief    : Loadable down-counter stepped by frame ticks; done while at zero.
// Revision : 1.0
// ============================================================================
module match_sequencer_frame_timer #(
    parameter int CNT_W = 1
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             load_i,
    input  wire logic [CNT_W-1:0] load_value_i,
    input  wire logic             tick_i,
    output logic                  done_o
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (load_i) begin
            r_count <= load_value_i;
        end else if (tick_i && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done_o = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/match_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : match_sequencer
// Brief    : Pong match flow: idle, serve countdown, play, point pause, game over.
// Revision : 1.0
// ============================================================================
module match_sequencer #(
    parameter int KEYS_W       = match_sequencer_pkg::KEYS_W,
    parameter int START_KEY    = 0,
    parameter int SCORE_W      = match_sequencer_pkg::SCORE_W,
    parameter int WIN_SCORE    = match_sequencer_pkg::WIN_SCORE,
    parameter int SERVE_FRAMES = match_sequencer_pkg::SERVE_FRAMES,
    parameter int POINT_FRAMES = match_sequencer_pkg::POINT_FRAMES
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    match_sequencer_if.slave  bus
);
    import match_sequencer_pkg::*;

    localparam int c_cnt_w = cnt_width(SERVE_FRAMES, POINT_FRAMES);
    localparam logic [c_cnt_w-1:0] c_serve_load = c_cnt_w'(SERVE_FRAMES - 1);
    localparam logic [c_cnt_w-1:0] c_point_load = c_cnt_w'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] c_win_m1     = SCORE_W'(WIN_SCORE - 1);

    match_state_t       r_state, w_state_next;
    logic [SCORE_W-1:0] r_player_score, w_player_score_next;
    logic [SCORE_W-1:0] r_enemy_score, w_enemy_score_next;
    logic               r_serve, w_serve_next;
    logic               r_serve_dir, w_serve_dir_next;
    logic               r_winner, w_winner_next;
    logic               r_key_prev, w_key_prev_next;

    logic               w_key;
    logic               w_press;
    logic               w_load;
    logic [c_cnt_w-1:0] w_load_value;
    logic               w_tick;
    logic               w_done;

    // Key is only sampled on frame ticks, which debounces it at frame rate.
    assign w_key   = bus.keys_i[START_KEY];
    assign w_press = bus.new_frame_i & w_key & ~r_key_prev;
    assign w_tick  = bus.new_frame_i &
                     ((r_state == ST_SERVE_WAIT) || (r_state == ST_POINT));

    match_sequencer_frame_timer #(
        .CNT_W (c_cnt_w)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (w_load),
        .load_value_i (w_load_value),
        .tick_i       (w_tick),
        .done_o       (w_done)
    );

    always_comb begin
        w_state_next        = r_state;
        w_player_score_next = r_player_score;
        w_enemy_score_next  = r_enemy_score;
        w_serve_next        = 1'b0;
        w_serve_dir_next    = r_serve_dir;
        w_winner_next       = r_winner;
        w_key_prev_next     = bus.new_frame_i ? w_key : r_key_prev;
        w_load              = 1'b0;
        w_load_value        = c_serve_load;

        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_player_score_next = '0;
                    w_enemy_score_next  = '0;
                    w_winner_next       = 1'b0;
                    w_serve_dir_next    = 1'b1;
                    w_load              = 1'b1;
                    w_state_next        = ST_SERVE_WAIT;
                end
            end
            ST_SERVE_WAIT: begin
                if (bus.new_frame_i && w_done) begin
                    w_serve_next = 1'b1;
                    w_state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Player goal wins a tie; the next serve heads toward the point's loser.
                if (bus.player_goal_i) begin
                    w_player_score_next = r_player_score + 1'b1;
                    w_serve_dir_next    = 1'b0;
                    if (r_player_score == c_win_m1) begin
                        w_winner_next = 1'b0;
                        w_state_next  = ST_GAME_OVER;
                    end else begin
                        w_load       = 1'b1;
                        w_load_value = c_point_load;
                        w_state_next = ST_POINT;
                    end
                end else if (bus.enemy_goal_i) begin
                    w_enemy_score_next = r_enemy_score + 1'b1;
                    w_serve_dir_next   = 1'b1;
                    if (r_enemy_score == c_win_m1) begin
                        w_winner_next = 1'b1;
                        w_state_next  = ST_GAME_OVER;
                    end else begin
                        w_load       = 1'b1;
                        w_load_value = c_point_load;
                        w_state_next = ST_POINT;
                    end
                end
            end
            ST_POINT: begin
                if (bus.new_frame_i && w_done) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SERVE_WAIT;
                end
            end
            ST_GAME_OVER: begin
                if (w_press) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state        <= ST_IDLE;
            r_player_score <= '0;
            r_enemy_score  <= '0;
            r_serve        <= 1'b0;
            r_serve_dir    <= 1'b1;
            r_winner       <= 1'b0;
            r_key_prev     <= 1'b1;
        end else begin
            r_state        <= w_state_next;
            r_player_score <= w_player_score_next;
            r_enemy_score  <= w_enemy_score_next;
            r_serve        <= w_serve_next;
            r_serve_dir    <= w_serve_dir_next;
            r_winner       <= w_winner_next;
            r_key_prev     <= w_key_prev_next;
        end
    end

    assign bus.run_o          = (r_state == ST_PLAY);
    assign bus.serve_o        = r_serve;
    assign bus.serve_dir_o    = r_serve_dir;
    assign bus.player_score_o = r_player_score;
    assign bus.enemy_score_o  = r_enemy_score;
    assign bus.winner_o       = r_winner;
    assign bus.state_o        = r_state;
endmodule
`default_nettype wire
